// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: the I/O register map,
// the controller state encoding and the default RAM depth.
package dmem_pkg;

    localparam int RAM_WORDS_DEFAULT = 256;

    localparam logic [31:0] GPIO_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] CYCLE_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] STCNT_ADDR = 32'hFFFF_0008;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM with an asynchronous read port and one synchronous write port.
// Contents are not reset; the owner zeroes them by sweeping the write port.
module dmem_ram #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [WORDS];

    // Single write port, committed on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dmem_resp.sv
// MEM-stage data responder: RAM plus GPIO / cycle-counter / store-counter registers,
// with a post-reset sweep that zeroes the RAM before any access is honoured.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = RAM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        busy,
    output logic [31:0] gpio,
    output logic        err
);

    localparam int AW = $clog2(RAM_WORDS);

    state_t         state_r;
    logic [AW-1:0]  clr_idx_r;
    logic           busy_r;
    logic [31:0]    cycle_r;
    logic [31:0]    stcnt_r;
    logic [31:0]    gpio_r;
    logic           err_r;

    logic           aligned_s;
    logic           sel_ram_s;
    logic           sel_gpio_s;
    logic           sel_cycle_s;
    logic           sel_stcnt_s;
    logic           run_s;
    logic           st_ram_s;
    logic           st_gpio_s;
    logic           st_stcnt_s;
    logic           st_bad_s;
    logic           ram_we_s;
    logic [AW-1:0]  ram_waddr_s;
    logic [31:0]    ram_wdata_s;
    logic [31:0]    ram_rdata_s;

    // Address decode and store classification; nothing is accepted while clearing.
    always_comb begin
        aligned_s   = (a[1:0] == 2'b00);
        sel_ram_s   = (a[31:AW+2] == {(30-AW){1'b0}});
        sel_gpio_s  = (a == GPIO_ADDR);
        sel_cycle_s = (a == CYCLE_ADDR);
        sel_stcnt_s = (a == STCNT_ADDR);
        run_s       = (state_r == ST_RUN);
        st_ram_s    = run_s & memwrite & aligned_s & sel_ram_s;
        st_gpio_s   = run_s & memwrite & sel_gpio_s;
        st_stcnt_s  = run_s & memwrite & sel_stcnt_s;
        st_bad_s    = run_s & memwrite &
                      ~(aligned_s & (sel_ram_s | sel_gpio_s | sel_stcnt_s));
    end

    // RAM write port is owned by the clear sweep until the controller reaches RUN.
    always_comb begin
        if (reset) begin
            ram_we_s    = 1'b0;
            ram_waddr_s = clr_idx_r;
            ram_wdata_s = 32'h0000_0000;
        end else if (state_r == ST_CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_idx_r;
            ram_wdata_s = 32'h0000_0000;
        end else begin
            ram_we_s    = st_ram_s;
            ram_waddr_s = a[AW+1:2];
            ram_wdata_s = wd;
        end
    end

    dmem_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (a[AW+1:2]),
        .rdata (ram_rdata_s)
    );

    // Zero-latency load mux; misaligned, unmapped or during-clear reads give zero.
    always_comb begin
        rd = 32'h0000_0000;
        if (run_s && aligned_s) begin
            if (sel_ram_s) begin
                rd = ram_rdata_s;
            end else if (sel_gpio_s) begin
                rd = gpio_r;
            end else if (sel_cycle_s) begin
                rd = cycle_r;
            end else if (sel_stcnt_s) begin
                rd = stcnt_r;
            end else begin
                rd = 32'h0000_0000;
            end
        end else begin
            rd = 32'h0000_0000;
        end
    end

    // Clear/run controller: sweep one RAM word per cycle, then hold in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= {AW{1'b0}};
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + AW'(1);
                    if (clr_idx_r == AW'(RAM_WORDS - 1)) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_idx_r <= {AW{1'b0}};
                    busy_r    <= 1'b1;
                end
            endcase
        end
    end

    // Memory-mapped registers; a store to STCNT clears it and is not itself counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_r <= 32'h0000_0000;
            stcnt_r <= 32'h0000_0000;
            gpio_r  <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            cycle_r <= cycle_r + 32'd1;
            if (st_stcnt_s) begin
                stcnt_r <= 32'h0000_0000;
            end else if (st_ram_s || st_gpio_s) begin
                stcnt_r <= sat_inc32(stcnt_r);
            end
            if (st_gpio_s) begin
                gpio_r <= wd;
            end
            if (st_bad_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign busy = busy_r;
    assign gpio = gpio_r;
    assign err  = err_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: each stimulus step queues its expected
// outputs; a negedge monitor pops and compares them.
module tb_dmem_resp;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        busy;
    logic [31:0] gpio;
    logic        err;

    dmem_resp #(.RAM_WORDS(256)) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .busy     (busy),
        .gpio     (gpio),
        .err      (err)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        busy;
        logic [31:0] gpio;
        logic        err;
        logic [3:0]  msk;   // [0] rd, [1] busy, [2] gpio, [3] err
    } exp_t;

    exp_t  exp_q [$];
    string name_q[$];
    logic  probe;
    int    total;
    int    bad;
    exp_t  cur;
    string cur_nm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue what the DUT must show.
    task automatic step(input string nm, input logic rst, input logic mw,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] e_rd, input logic e_busy,
                        input logic [31:0] e_gpio, input logic e_err,
                        input logic [3:0] msk);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        memwrite = mw;
        a        = addr;
        wd       = data;
        e.rd = e_rd; e.busy = e_busy; e.gpio = e_gpio; e.err = e_err; e.msk = msk;
        exp_q.push_back(e);
        name_q.push_back(nm);
        probe = 1'b1;
    endtask

    // Monitor: compare queued expectations against the DUT mid-cycle.
    always @(negedge clk) begin
        if (probe) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                cur    = exp_q.pop_front();
                cur_nm = name_q.pop_front();
                if (cur.msk[0]) begin
                    total++;
                    if (rd !== cur.rd) begin
                        bad++;
                        $display("FAIL %s rd: got %h expected %h", cur_nm, rd, cur.rd);
                    end
                end
                if (cur.msk[1]) begin
                    total++;
                    if (busy !== cur.busy) begin
                        bad++;
                        $display("FAIL %s busy: got %b expected %b", cur_nm, busy, cur.busy);
                    end
                end
                if (cur.msk[2]) begin
                    total++;
                    if (gpio !== cur.gpio) begin
                        bad++;
                        $display("FAIL %s gpio: got %h expected %h", cur_nm, gpio, cur.gpio);
                    end
                end
                if (cur.msk[3]) begin
                    total++;
                    if (err !== cur.err) begin
                        bad++;
                        $display("FAIL %s err: got %b expected %b", cur_nm, err, cur.err);
                    end
                end
            end
        end
    end

    initial begin
        logic        mw;
        logic [31:0] ad;
        logic [31:0] dt;
        total    = 0;
        bad      = 0;
        probe    = 1'b0;
        reset    = 1'b1;
        memwrite = 1'b0;
        a        = 32'h0;
        wd       = 32'h0;

        // Reset sampled on the first edge, then a 256-cycle clear sweep.
        for (int k = 0; k < 256; k++) begin
            step("clear1", 1'b0, 1'b0, 32'h0000_0010, 32'h0,
                 32'h0, 1'b1, 32'h0, 1'b0, 4'hF);
        end
        step("cycle1",     1'b0, 1'b0, 32'hFFFF_0004, 32'h0, 32'd256,       1'b0, 32'h0, 1'b0, 4'hF);
        step("st_ram",     1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 1'b0, 4'hF);
        step("ld_ram",     1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 4'hF);
        step("stcnt_1",    1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 32'd1,         1'b0, 32'h0, 1'b0, 4'hF);
        step("st_mis",     1'b0, 1'b1, 32'h0000_0006, 32'h1111_1111, 32'h0, 1'b0, 32'h0, 1'b0, 4'hF);
        step("st_unmap",   1'b0, 1'b1, 32'h1234_0000, 32'h2222_2222, 32'h0, 1'b0, 32'h0, 1'b1, 4'hF);
        step("ld_kept",    1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 4'hF);
        step("rd_mis",     1'b0, 1'b0, 32'h0000_0005, 32'h0, 32'h0,         1'b0, 32'h0, 1'b1, 4'hF);
        step("stcnt_kept", 1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 32'd1,         1'b0, 32'h0, 1'b1, 4'hF);
        step("st_gpio",    1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_00A5, 32'h0, 1'b0, 32'h0, 1'b1, 4'hF);
        step("ld_gpio",    1'b0, 1'b0, 32'hFFFF_0000, 32'h0, 32'hA5,        1'b0, 32'hA5, 1'b1, 4'hF);
        step("stcnt_2",    1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 32'd2,         1'b0, 32'hA5, 1'b1, 4'hF);
        step("st_stcnt",   1'b0, 1'b1, 32'hFFFF_0008, 32'h55, 32'd2,        1'b0, 32'hA5, 1'b1, 4'hF);
        step("stcnt_clr",  1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 32'd0,         1'b0, 32'hA5, 1'b1, 4'hF);
        step("st_last",    1'b0, 1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, 32'h0, 1'b0, 32'hA5, 1'b1, 4'hF);
        step("ld_last",    1'b0, 1'b0, 32'h0000_03FC, 32'h0, 32'h0BAD_CAFE, 1'b0, 32'hA5, 1'b1, 4'hF);
        step("st_oob",     1'b0, 1'b1, 32'h0000_0400, 32'h3333_3333, 32'h0, 1'b0, 32'hA5, 1'b1, 4'hF);
        step("ld_idx0",    1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0,         1'b0, 32'hA5, 1'b1, 4'hF);
        step("stcnt_3",    1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 32'd1,         1'b0, 32'hA5, 1'b1, 4'hF);
        step("st_cycle",   1'b0, 1'b1, 32'hFFFF_0004, 32'h4444_4444, 32'h0, 1'b0, 32'hA5, 1'b1, 4'hE);
        step("stcnt_4",    1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 32'd1,         1'b0, 32'hA5, 1'b1, 4'hF);

        // Reset again, then re-assert it when the sweep reaches index 100.
        step("rst_req",    1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'hA5, 1'b1, 4'hF);
        for (int k = 0; k <= 100; k++) begin
            step("clear2a", (k == 100), 1'b0, 32'h0000_0004, 32'h0,
                 32'h0, 1'b1, 32'h0, 1'b0, 4'hF);
        end
        // Restarted sweep with stores that must all be ignored.
        for (int k = 0; k < 256; k++) begin
            mw = 1'b0; ad = 32'h0000_0010; dt = 32'h0;
            if (k == 10)  begin mw = 1'b1; ad = 32'hFFFF_0000; dt = 32'h0000_00FF; end
            if (k == 20)  begin mw = 1'b1; ad = 32'h0000_0006; dt = 32'h6666_6666; end
            if (k == 255) begin mw = 1'b1; ad = 32'h0000_0000; dt = 32'h0000_0077; end
            step("clear2b", 1'b0, mw, ad, dt, 32'h0, 1'b1, 32'h0, 1'b0, 4'hF);
        end
        step("cycle2",  1'b0, 1'b0, 32'hFFFF_0004, 32'h0, 32'd256, 1'b0, 32'h0, 1'b0, 4'hF);
        step("ld0_2",   1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0,   1'b0, 32'h0, 1'b0, 4'hF);
        step("ld4_2",   1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h0,   1'b0, 32'h0, 1'b0, 4'hF);
        step("ld3fc_2", 1'b0, 1'b0, 32'h0000_03FC, 32'h0, 32'h0,   1'b0, 32'h0, 1'b0, 4'hF);
        step("stcnt_5", 1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 32'd0,   1'b0, 32'h0, 1'b0, 4'hF);

        @(posedge clk);
        #1;
        probe = 1'b0;
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
